// File: rtl/mcp23s17_spi_master.sv
// Register-access SPI master (mode 0, 24-bit frames) for the MCP23S17 GPIO expander,
// plus a synchroniser that turns the expander's INTA line into an interrupt pulse.
module mcp23s17_spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   output logic       ready,
   input  logic       rw,
   input  logic [2:0] hw_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       spi_sck,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_cs_n,
   input  logic       inta_n,
   output logic       irq,
   output logic       int_active
);

   localparam int DIV_W = $clog2(CLK_DIV);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SHIFT   = 2'd1;
   localparam logic [1:0] ST_CS_HOLD = 2'd2;
   localparam logic [1:0] ST_CS_GAP  = 2'd3;

   logic [1:0]       state;
   logic [DIV_W-1:0] div_cnt;
   logic [4:0]       bit_cnt;
   logic [23:0]      tx_sr;
   logic [7:0]       rx_sr;
   logic             is_read;
   logic             miso_p0, miso_p1;
   logic             inta_p0, inta_p1, inta_p2;
   logic             phase_end;
   logic [23:0]      frame_in;

   assign phase_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign frame_in   = {4'b0100, hw_addr, rw, reg_addr, rw ? 8'h00 : wr_data};
   assign ready      = (state == ST_IDLE);
   assign int_active = ~inta_p1;

   // Control path: frame sequencing, SPI pins and read completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         spi_sck  <= 1'b0;
         spi_cs_n <= 1'b1;
         spi_mosi <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= 8'h00;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  state    <= ST_SHIFT;
                  spi_cs_n <= 1'b0;
                  spi_mosi <= frame_in[23];
                  spi_sck  <= 1'b0;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
               end
            end
            ST_SHIFT: begin
               if (phase_end) begin
                  div_cnt <= '0;
                  if (!spi_sck) begin
                     spi_sck <= 1'b1;
                  end else begin
                     // Falling edge: present the next bit in the same cycle.
                     spi_sck <= 1'b0;
                     if (bit_cnt == 5'd23) begin
                        state    <= ST_CS_HOLD;
                        spi_mosi <= 1'b0;
                     end else begin
                        bit_cnt  <= bit_cnt + 5'd1;
                        spi_mosi <= tx_sr[22];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_CS_HOLD: begin
               if (phase_end) begin
                  div_cnt  <= '0;
                  spi_cs_n <= 1'b1;
                  state    <= ST_CS_GAP;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_CS_GAP: begin
               if (phase_end) begin
                  div_cnt <= '0;
                  state   <= ST_IDLE;
                  if (is_read) begin
                     rd_valid <= 1'b1;
                     rd_data  <= rx_sr;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Data path: frame shift register and MISO capture at the end of each high phase.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && req) begin
         tx_sr   <= frame_in;
         is_read <= rw;
      end else if (state == ST_SHIFT && phase_end && spi_sck) begin
         tx_sr <= {tx_sr[22:0], 1'b0};
         rx_sr <= {rx_sr[6:0], miso_p1};
      end
   end

   // Synchronisers: p0/p1 form the 2-flop chain, inta_p2 is the previous synchronised INTA.
   always_ff @(posedge clk) begin
      if (reset) begin
         miso_p0 <= 1'b1;
         miso_p1 <= 1'b1;
         inta_p0 <= 1'b1;
         inta_p1 <= 1'b1;
         inta_p2 <= 1'b1;
         irq     <= 1'b0;
      end else begin
         miso_p0 <= spi_miso;
         miso_p1 <= miso_p0;
         inta_p0 <= inta_n;
         inta_p1 <= inta_p0;
         inta_p2 <= inta_p1;
         irq     <= inta_p2 & ~inta_p1;
      end
   end

endmodule

// File: tb/tb_mcp23s17_spi_master.sv
// Scoreboard bench for mcp23s17_spi_master: frame contents, timing, reads, abort and INTA.
`timescale 1ns/1ps
module tb_mcp23s17_spi_master;

   localparam int D  = 4;
   localparam int D2 = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req = 1'b0, req2 = 1'b0;
   logic       rw = 1'b0;
   logic [2:0] hw_addr = 3'd0;
   logic [7:0] reg_addr = 8'h00, wr_data = 8'h00;
   logic       spi_miso = 1'b0, spi_miso2 = 1'b0;
   logic       inta_n = 1'b1;

   logic       ready, rd_valid, spi_sck, spi_mosi, spi_cs_n, irq, int_active;
   logic [7:0] rd_data;
   logic       ready2, rd_valid2, spi_sck2, spi_mosi2, spi_cs_n2, irq2, int_active2;
   logic [7:0] rd_data2;

   mcp23s17_spi_master #(.CLK_DIV(D)) u_dut (
      .clk(clk), .reset(reset), .req(req), .ready(ready), .rw(rw),
      .hw_addr(hw_addr), .reg_addr(reg_addr), .wr_data(wr_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .inta_n(inta_n), .irq(irq),
      .int_active(int_active)
   );

   mcp23s17_spi_master #(.CLK_DIV(D2)) u_dut2 (
      .clk(clk), .reset(reset), .req(req2), .ready(ready2), .rw(rw),
      .hw_addr(hw_addr), .reg_addr(reg_addr), .wr_data(wr_data),
      .rd_data(rd_data2), .rd_valid(rd_valid2), .spi_sck(spi_sck2), .spi_mosi(spi_mosi2),
      .spi_miso(spi_miso2), .spi_cs_n(spi_cs_n2), .inta_n(inta_n), .irq(irq2),
      .int_active(int_active2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [23:0] frame;
      bit          rd;
      logic [7:0]  data;
   } txn_t;

   txn_t       sb_q[$];
   logic [7:0] miso_q[$];
   txn_t       exp_t;
   logic [7:0] model_rd = 8'h00;

   function automatic logic [23:0] mk_frame(input bit r, input logic [2:0] hw,
                                            input logic [7:0] ra, input logic [7:0] wd);
      return {4'b0100, hw, r, ra, r ? 8'h00 : wd};
   endfunction

   // Expander model: shifts the read byte out during the third byte, changing on SCK falls.
   logic [7:0] miso_cur = 8'h00;
   int         nf = 0;
   always @(negedge spi_cs_n) begin
      miso_cur = 8'h00;
      if (miso_q.size() > 0) miso_cur = miso_q.pop_front();
      nf = 0;
      spi_miso = 1'b0;
   end
   always @(negedge spi_sck) begin
      if (!spi_cs_n) begin
         nf++;
         if (nf >= 16 && nf <= 23) spi_miso = miso_cur[23-nf];
      end
   end

   logic [7:0] miso2_byte = 8'h00;
   int         nf2 = 0;
   always @(negedge spi_cs_n2) begin
      nf2 = 0;
      spi_miso2 = 1'b0;
   end
   always @(negedge spi_sck2) begin
      if (!spi_cs_n2) begin
         nf2++;
         if (nf2 >= 16 && nf2 <= 23) spi_miso2 = miso2_byte[23-nf2];
         else spi_miso2 = 1'($urandom_range(1, 0));
      end
   end

   // Frame monitor on the opposite clock edge.
   bit          open = 1'b0, rv_next = 1'b0;
   int          t_fall = 0, t_high = 0, last_gap = 0, rises = 0, done_cnt = 0;
   logic [23:0] cap = '0;
   logic        p_cs = 1'b1, p_sck = 1'b0, p_rdy = 1'b1;

   always @(negedge clk) begin
      if (rv_next) begin
         check("rd_valid_width", rd_valid, 1'b0);
         rv_next = 1'b0;
      end
      if (reset) begin
         open = 1'b0;
         model_rd = 8'h00;
      end else begin
         if (p_cs && !spi_cs_n) begin
            open = 1'b1;
            last_gap = cyc - t_high;
            t_fall = cyc;
            cap = '0;
            rises = 0;
         end
         if (!p_sck && spi_sck) begin
            cap = {cap[22:0], spi_mosi};
            rises++;
         end
         if (!p_cs && spi_cs_n) t_high = cyc;
         if (open && !p_rdy && ready) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_frame", 32'd1, 32'd0);
            end else begin
               exp_t = sb_q.pop_front();
               check("mosi_frame", cap, exp_t.frame);
               check("sck_rises", rises, 24);
               check("cs_low_len", t_high - t_fall, 49 * D);
               check("ready_latency", cyc - t_fall, 50 * D);
               check("rd_valid", rd_valid, exp_t.rd);
               check("rd_data", rd_data, exp_t.rd ? exp_t.data : model_rd);
               check("idle_mosi_sck", {spi_mosi, spi_sck}, 2'b00);
               if (exp_t.rd) model_rd = exp_t.data;
               rv_next = exp_t.rd;
            end
            open = 1'b0;
            done_cnt++;
         end
      end
      p_cs  = spi_cs_n;
      p_sck = spi_sck;
      p_rdy = ready;
   end

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic scramble();
      rw       = 1'($urandom_range(1, 0));
      hw_addr  = 3'($urandom);
      reg_addr = 8'($urandom);
      wr_data  = 8'($urandom);
   endtask

   task automatic send(input bit r, input logic [2:0] hw, input logic [7:0] ra,
                       input logic [7:0] wd, input logic [7:0] md, input bit score);
      @(negedge clk);
      wait_ready();
      rw = r; hw_addr = hw; reg_addr = ra; wr_data = wd;
      miso_q.push_back(md);
      if (score) sb_q.push_back('{mk_frame(r, hw, ra, wd), r, md});
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      scramble();
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt < target) check("done_timeout", done_cnt, target);
   endtask

   task automatic inta_test();
      @(posedge clk); #1; inta_n = 1'b0;
      @(posedge clk); #1; check("int_active_e1", int_active, 1'b0);
      @(posedge clk); #1; check("int_active_e2", int_active, 1'b1);
      check("irq_e2", irq, 1'b0);
      @(posedge clk); #1; check("irq_e3", irq, 1'b1);
      @(posedge clk); #1; check("irq_e4", irq, 1'b0);
      repeat (6) @(posedge clk);
      #1; inta_n = 1'b1;
      @(posedge clk); #1; check("int_active_r1", int_active, 1'b1);
      @(posedge clk); #1; check("int_active_r2", int_active, 1'b0);
      check("irq_rise", irq, 1'b0);
   endtask

   task automatic dut2_read(input logic [2:0] hw, input logic [7:0] ra, input logic [7:0] md);
      int t0;
      int n = 0;
      @(negedge clk);
      check("d2_ready", ready2, 1'b1);
      rw = 1'b1; hw_addr = hw; reg_addr = ra; miso2_byte = md;
      req2 = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1;
      req2 = 1'b0;
      scramble();
      while (!rd_valid2 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("d2_rd_valid", rd_valid2, 1'b1);
      check("d2_latency", cyc - t0, 1 + 50 * D2);
      check("d2_rd_data", rd_data2, md);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int rv;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ready, 1'b1);
      check("rst_cs_n", spi_cs_n, 1'b1);
      check("rst_sck", spi_sck, 1'b0);
      check("rst_mosi", spi_mosi, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_irq", irq, 1'b0);
      check("rst_int_active", int_active, 1'b0);
      reset = 1'b0;

      send(1'b0, 3'd0, 8'h00, 8'hF0, 8'h00, 1'b1);
      wait_done(1);
      send(1'b1, 3'd1, 8'h12, 8'h00, 8'hA5, 1'b1);
      wait_done(2);

      // Back-to-back: req held high across two accepts.
      @(negedge clk);
      wait_ready();
      rw = 1'b0; hw_addr = 3'd7; reg_addr = 8'h0A; wr_data = 8'h5C;
      miso_q.push_back(8'h00);
      miso_q.push_back(8'h3C);
      sb_q.push_back('{mk_frame(1'b0, 3'd7, 8'h0A, 8'h5C), 1'b0, 8'h00});
      req = 1'b1;
      @(posedge clk);
      #1;
      rw = 1'b1; hw_addr = 3'd2; reg_addr = 8'h13; wr_data = 8'h77;
      sb_q.push_back('{mk_frame(1'b1, 3'd2, 8'h13, 8'h77), 1'b1, 8'h3C});
      wait_done(3);
      @(posedge clk);
      #1;
      req = 1'b0;
      scramble();
      wait_done(4);
      check("b2b_gap", last_gap, D + 1);

      // Reset in the middle of a read.
      send(1'b1, 3'd6, 8'h05, 8'h00, 8'hFF, 1'b0);
      n = 0;
      while (!(open && rises >= 10) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_bit10", rises, 10);
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1;
      check("abort_cs_n", spi_cs_n, 1'b1);
      check("abort_sck", spi_sck, 1'b0);
      check("abort_ready", ready, 1'b1);
      check("abort_mosi", spi_mosi, 1'b0);
      reset = 1'b0;
      rv = 0;
      repeat (250) begin
         @(negedge clk);
         if (rd_valid) rv++;
      end
      check("abort_no_rd_valid", rv, 0);
      check("abort_no_completion", done_cnt, 4);
      send(1'b1, 3'd0, 8'h09, 8'h00, 8'h96, 1'b1);
      wait_done(5);

      // Interrupt path, idle and then during a frame.
      inta_test();
      send(1'b0, 3'd4, 8'h14, 8'h81, 8'h00, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      check("inta_frame_active", spi_cs_n, 1'b0);
      inta_test();
      wait_done(6);

      // CLK_DIV=2 instance with MISO toggling right after every SCK fall.
      dut2_read(3'd5, 8'h13, 8'h3C);
      dut2_read(3'd3, 8'h09, 8'hC3);

      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
